// File: rtl/matrix_pkg.sv
//==============================================================================
// matrix_pkg: FSM encoding and index helper shared by the matrix_mem_burst blocks
// Revision: 1.0
//==============================================================================
`default_nettype none

package matrix_pkg;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_BURST = 1'b1
    } state_t;

    function automatic logic idx_in_range(input int unsigned idx, input int unsigned n);
        return idx < n;
    endfunction

endpackage

`default_nettype wire

// File: rtl/matrix_burst_ctr.sv
//==============================================================================
// matrix_burst_ctr: burst element index with last-element compare
// Revision: 1.0
//==============================================================================
`default_nettype none

module matrix_burst_ctr #(
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             advance,
    input  logic [CNT_W-1:0] limit,
    output logic [CNT_W-1:0] idx,
    output logic             is_last
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (advance && !is_last) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign idx     = cnt_q;
    assign is_last = (cnt_q == limit);

endmodule

`default_nettype wire

// File: rtl/matrix_mem_burst.sv
//==============================================================================
// matrix_mem_burst: ROWS x COLS store with single-element access and row/column burst reads
// Revision: 1.0
//==============================================================================
`default_nettype none

module matrix_mem_burst
    import matrix_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int ROWS       = 10,
    parameter int COLS       = 10,
    parameter int ADDR_W     = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en_ReadMat,
    input  logic                  en_WriteMat,
    input  logic [ADDR_W-1:0]     rowAddr,
    input  logic [ADDR_W-1:0]     colAddr,
    input  logic [DATA_WIDTH-1:0] writeData,
    input  logic                  burst_start,
    input  logic                  burst_col,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] readData,
    output logic                  readValid,
    output logic                  burst_last,
    output logic                  busy,
    output logic                  addr_err
);

    localparam logic [ADDR_W-1:0] ROW_BURST_LAST = ADDR_W'(COLS - 1);
    localparam logic [ADDR_W-1:0] COL_BURST_LAST = ADDR_W'(ROWS - 1);

    logic [DATA_WIDTH-1:0] mem [ROWS][COLS];

    state_t                state_q, state_d;
    logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
    logic                  rd_valid_q, rd_valid_d;
    logic                  last_q, last_d;
    logic                  err_q, err_d;
    logic                  sel_col_q, sel_col_d;
    logic [ADDR_W-1:0]     fix_q, fix_d;

    logic                  mem_we;
    logic                  ctr_clear, ctr_adv, ctr_last;
    logic [ADDR_W-1:0]     ctr_idx, burst_limit, b_row, b_col;
    logic                  row_ok, col_ok, sel_ok;

    assign row_ok      = idx_in_range(32'(rowAddr), ROWS);
    assign col_ok      = idx_in_range(32'(colAddr), COLS);
    assign sel_ok      = burst_col ? col_ok : row_ok;
    assign burst_limit = sel_col_q ? COL_BURST_LAST : ROW_BURST_LAST;
    assign b_row       = sel_col_q ? ctr_idx : fix_q;
    assign b_col       = sel_col_q ? fix_q : ctr_idx;

    matrix_burst_ctr #(
        .CNT_W (ADDR_W)
    ) u_ctr (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (ctr_clear),
        .advance (ctr_adv),
        .limit   (burst_limit),
        .idx     (ctr_idx),
        .is_last (ctr_last)
    );

    always_comb begin
        state_d    = state_q;
        rd_data_d  = rd_data_q;
        rd_valid_d = rd_valid_q;
        last_d     = last_q;
        err_d      = 1'b0;
        sel_col_d  = sel_col_q;
        fix_d      = fix_q;
        mem_we     = 1'b0;
        ctr_clear  = 1'b0;
        ctr_adv    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                rd_valid_d = 1'b0;
                last_d     = 1'b0;
                if (burst_start) begin
                    if (sel_ok) begin
                        state_d   = ST_BURST;
                        sel_col_d = burst_col;
                        fix_d     = burst_col ? colAddr : rowAddr;
                        ctr_clear = 1'b1;
                    end else begin
                        err_d = 1'b1;
                    end
                end else if (en_WriteMat && !en_ReadMat) begin
                    if (row_ok && col_ok) begin
                        mem_we = rst_n;
                    end else begin
                        err_d = 1'b1;
                    end
                end else if (en_ReadMat && !en_WriteMat) begin
                    if (row_ok && col_ok) begin
                        rd_data_d  = mem[rowAddr][colAddr];
                        rd_valid_d = 1'b1;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            ST_BURST: begin
                // Fetch on the entry cycle and on every accept that is not the final one
                if (!rd_valid_q || (out_ready && !last_q)) begin
                    rd_data_d  = mem[b_row][b_col];
                    rd_valid_d = 1'b1;
                    last_d     = ctr_last;
                    ctr_adv    = 1'b1;
                end else if (out_ready && last_q) begin
                    rd_valid_d = 1'b0;
                    last_d     = 1'b0;
                    state_d    = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
            last_q     <= 1'b0;
            err_q      <= 1'b0;
            sel_col_q  <= 1'b0;
            fix_q      <= '0;
        end else begin
            state_q    <= state_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
            last_q     <= last_d;
            err_q      <= err_d;
            sel_col_q  <= sel_col_d;
            fix_q      <= fix_d;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[rowAddr][colAddr] <= writeData;
        end
    end

    assign readData   = rd_data_q;
    assign readValid  = rd_valid_q;
    assign burst_last = last_q;
    assign busy       = (state_q == ST_BURST);
    assign addr_err   = err_q;

endmodule

`default_nettype wire

// File: tb/tb_matrix_mem_burst.sv
//==============================================================================
// tb_matrix_mem_burst: randomized scoreboard bench for matrix_mem_burst
// Revision: 1.0
//==============================================================================
`default_nettype none

module tb_matrix_mem_burst;

    localparam int DW = 8;
    localparam int NR = 10;
    localparam int NC = 10;
    localparam int AW = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          en_ReadMat = 1'b0;
    logic          en_WriteMat = 1'b0;
    logic [AW-1:0] rowAddr = '0;
    logic [AW-1:0] colAddr = '0;
    logic [DW-1:0] writeData = '0;
    logic          burst_start = 1'b0;
    logic          burst_col = 1'b0;
    logic          out_ready = 1'b1;
    logic [DW-1:0] readData;
    logic          readValid;
    logic          burst_last;
    logic          busy;
    logic          addr_err;

    int checks = 0;
    int errors = 0;

    logic [DW-1:0] ref_mem [NR][NC];
    logic [DW:0]   exp_q [$];

    always #5 clk = ~clk;

    matrix_mem_burst #(
        .DATA_WIDTH (DW),
        .ROWS       (NR),
        .COLS       (NC),
        .ADDR_W     (AW)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .en_ReadMat  (en_ReadMat),
        .en_WriteMat (en_WriteMat),
        .rowAddr     (rowAddr),
        .colAddr     (colAddr),
        .writeData   (writeData),
        .burst_start (burst_start),
        .burst_col   (burst_col),
        .out_ready   (out_ready),
        .readData    (readData),
        .readValid   (readValid),
        .burst_last  (burst_last),
        .busy        (busy),
        .addr_err    (addr_err)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit in_r(input int v, input int n);
        return (v >= 0) && (v < n);
    endfunction

    // Every presented element is compared with the head of the queue; it leaves on acceptance
    always @(negedge clk) begin
        if (readValid) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_valid: got data %0h last %0b, expected no output", readData, burst_last);
            end else begin
                chk("element", {readData, burst_last}, 32'(exp_q[0]));
                if (out_ready) void'(exp_q.pop_front());
            end
        end
    end

    task automatic idle_inputs();
        en_ReadMat  = 1'b0;
        en_WriteMat = 1'b0;
        burst_start = 1'b0;
    endtask

    task automatic do_write(input int r, input int c, input logic [DW-1:0] d);
        bit ok;
        ok = in_r(r, NR) && in_r(c, NC);
        rowAddr = AW'(r); colAddr = AW'(c); writeData = d; en_WriteMat = 1'b1;
        @(posedge clk); #1;
        idle_inputs();
        if (ok) ref_mem[r][c] = d;
        chk("write_addr_err", 32'(addr_err), 32'(!ok));
        chk("write_busy", 32'(busy), 0);
    endtask

    task automatic do_read(input int r, input int c);
        bit ok;
        ok = in_r(r, NR) && in_r(c, NC);
        if (ok) exp_q.push_back({ref_mem[r][c], 1'b0});
        out_ready = 1'b1;
        rowAddr = AW'(r); colAddr = AW'(c); en_ReadMat = 1'b1;
        @(posedge clk); #1;
        idle_inputs();
        chk("read_valid", 32'(readValid), 32'(ok));
        chk("read_addr_err", 32'(addr_err), 32'(!ok));
        @(posedge clk); #1;
        chk("read_valid_pulse", 32'(readValid), 0);
    endtask

    // mode: 0 ready always, 1 ready toggling starting high, 2 random ready
    task automatic do_burst(input bit col, input int idx, input int mode, input bit noise);
        bit ok;
        int n;
        int cyc;
        n  = col ? NR : NC;
        ok = in_r(idx, col ? NC : NR);
        if (ok) begin
            for (int k = 0; k < n; k++) begin
                if (col) exp_q.push_back({ref_mem[k][idx], k == n - 1});
                else     exp_q.push_back({ref_mem[idx][k], k == n - 1});
            end
        end
        burst_col = col;
        rowAddr = col ? AW'($urandom_range(0, NR - 1)) : AW'(idx);
        colAddr = col ? AW'(idx) : AW'($urandom_range(0, NC - 1));
        burst_start = 1'b1;
        // A single write in the same cycle must lose to the burst request
        en_WriteMat = noise;
        writeData   = DW'($urandom);
        @(posedge clk); #1;
        idle_inputs();
        chk("burst_busy", 32'(busy), 32'(ok));
        chk("burst_addr_err", 32'(addr_err), 32'(!ok));
        if (!ok) return;
        cyc = 0;
        while (exp_q.size() > 0 && cyc < 200) begin
            case (mode)
                0:       out_ready = 1'b1;
                1:       out_ready = (cyc % 2 == 0);
                default: out_ready = 1'($urandom);
            endcase
            if (noise) begin
                en_WriteMat = 1'($urandom);
                en_ReadMat  = 1'($urandom);
                burst_start = 1'($urandom);
                rowAddr     = AW'($urandom);
                colAddr     = AW'($urandom);
                writeData   = DW'($urandom);
            end
            @(posedge clk); #1;
            if (noise) chk("burst_noise_addr_err", 32'(addr_err), 0);
            cyc++;
        end
        idle_inputs();
        out_ready = 1'b1;
        if (exp_q.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL burst_timeout: %0d elements still pending, expected 0", exp_q.size());
            exp_q.delete();
        end
        chk("burst_end_busy", 32'(busy), 0);
        chk("burst_end_valid", 32'(readValid), 0);
    endtask

    task automatic chk_outputs_zero(input string tag);
        chk({tag, "_readData"}, 32'(readData), 0);
        chk({tag, "_readValid"}, 32'(readValid), 0);
        chk({tag, "_burst_last"}, 32'(burst_last), 0);
        chk({tag, "_busy"}, 32'(busy), 0);
        chk({tag, "_addr_err"}, 32'(addr_err), 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk_outputs_zero("reset");
        rst_n = 1'b1;
        @(posedge clk); #1;

        for (int r = 0; r < NR; r++)
            for (int c = 0; c < NC; c++)
                do_write(r, c, DW'($urandom));

        // Single write then read back
        do_write(3, 7, 8'hA5);
        do_read(3, 7);

        // Row burst over a known pattern, continuous ready
        for (int c = 0; c < NC; c++) do_write(2, c, DW'(8'h20 + c));
        do_burst(1'b0, 2, 0, 1'b0);

        // Column burst with ready toggling
        do_burst(1'b1, 4, 1, 1'b0);

        // Out-of-range requests
        do_write(10, 0, 8'hFF);
        do_burst(1'b0, 12, 0, 1'b0);
        do_burst(1'b1, 11, 0, 1'b0);
        do_read(0, 13);
        do_read(9, 0);

        // Both enables high: no access and no error, even out of range
        rowAddr = 4'd1; colAddr = 4'd1; writeData = ~ref_mem[1][1];
        en_ReadMat = 1'b1; en_WriteMat = 1'b1;
        @(posedge clk); #1;
        chk("both_en_err", 32'(addr_err), 0);
        chk("both_en_valid", 32'(readValid), 0);
        rowAddr = 4'd14;
        @(posedge clk); #1;
        idle_inputs();
        chk("both_en_oor_err", 32'(addr_err), 0);
        do_read(1, 1);

        // Requests during a burst are ignored
        do_burst(1'b0, 5, 2, 1'b1);
        do_burst(1'b1, 0, 2, 1'b1);

        // Reset on the 4th element of a row burst
        do_write(0, 0, 8'h5C);
        for (int k = 0; k < NC; k++) exp_q.push_back({ref_mem[1][k], k == NC - 1});
        burst_col = 1'b0; rowAddr = 4'd1; burst_start = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
        idle_inputs();
        repeat (4) @(posedge clk);
        #1;
        chk("pre_reset_valid", 32'(readValid), 1);
        chk("pre_reset_data", 32'(readData), 32'(ref_mem[1][3]));
        rst_n = 1'b0;
        exp_q.delete();
        #1;
        chk_outputs_zero("burst_reset");
        @(posedge clk); #1;
        chk_outputs_zero("burst_reset_held");
        rst_n = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        chk("post_reset_busy", 32'(busy), 0);
        do_read(0, 0);

        // Randomized mix
        for (int i = 0; i < 40; i++) begin
            case ($urandom_range(0, 2))
                0:       do_write($urandom_range(0, 11), $urandom_range(0, 11), DW'($urandom));
                1:       do_read($urandom_range(0, 11), $urandom_range(0, 11));
                default: do_burst(1'($urandom), $urandom_range(0, 11), $urandom_range(0, 2), 1'($urandom));
            endcase
        end

        // Full sweep confirms no stray writes reached the array
        for (int r = 0; r < NR; r++) do_burst(1'b0, r, 2, 1'b0);

        repeat (3) @(posedge clk);
        #1;
        chk("final_queue_empty", 32'(exp_q.size()), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/matrix_mem_burst.md
MATRIX_MEM_BURST -- requirements
Module: matrix_mem_burst

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 8, meaning element width in bits.
REQ-002 The block SHALL have parameter ROWS, default 10, meaning matrix row count (1..2**ADDR_W).
REQ-003 The block SHALL have parameter COLS, default 10, meaning matrix column count (1..2**ADDR_W).
REQ-004 The block SHALL have parameter ADDR_W, default 4, meaning width of the row and column index ports.
REQ-005 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-006 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-007 The block SHALL have port en_ReadMat, input, 1 bit: single-element read request.
REQ-008 The block SHALL have port en_WriteMat, input, 1 bit: single-element write request.
REQ-009 The block SHALL have ports rowAddr and colAddr, input, ADDR_W bits each: element or burst index.
REQ-010 The block SHALL have port writeData, input, DATA_WIDTH bits: write data.
REQ-011 The block SHALL have port burst_start, input, 1 bit: starts a burst read.
REQ-012 The block SHALL have port burst_col, input, 1 bit: 0 = row burst (row rowAddr), 1 = column burst (column colAddr).
REQ-013 The block SHALL have port out_ready, input, 1 bit: consumer accepts the current burst element.
REQ-014 The block SHALL have port readData, output, DATA_WIDTH bits: read result.
REQ-015 The block SHALL have port readValid, output, 1 bit: readData valid.
REQ-016 The block SHALL have port burst_last, output, 1 bit: the current valid element is the final element of the burst.
REQ-017 The block SHALL have port busy, output, 1 bit: a burst is in progress.
REQ-018 The block SHALL have port addr_err, output, 1 bit: one-cycle pulse flagging a rejected request.

Function
REQ-019 Storage SHALL be a ROWS x COLS array of DATA_WIDTH words with no reset.
REQ-020 The FSM SHALL have states IDLE and BURST; busy SHALL be 1 exactly in BURST.
REQ-021 In IDLE, en_WriteMat=1 with en_ReadMat=0 and an in-range index SHALL write writeData at the next edge.
REQ-022 In IDLE, en_ReadMat=1 with en_WriteMat=0 and an in-range index SHALL load readData at the next edge and pulse readValid for one cycle, independent of out_ready.
REQ-023 en_ReadMat and en_WriteMat both at 1 SHALL perform no operation and raise no error.
REQ-024 Priority in IDLE SHALL be burst_start over single read and write; a single access in the same cycle SHALL be dropped.
REQ-025 An out-of-range row or column, or an out-of-range selected index on burst_start, SHALL cause no memory or state change and SHALL pulse addr_err one cycle later.
REQ-026 A valid burst_start SHALL enter BURST; the first element SHALL appear, with readValid=1, one cycle later.
REQ-027 A row burst SHALL emit (r,0) through (r,COLS-1); a column burst SHALL emit (0,c) through (ROWS-1,c), one element per accepted transfer.
REQ-028 While readValid=1 and out_ready=0, readData, readValid and burst_last SHALL hold.
REQ-029 The element is accepted when readValid=1 and out_ready=1; the next element SHALL appear in the following cycle with no bubble.
REQ-030 burst_last SHALL be 1 only with the final element; acceptance of that element SHALL return the FSM to IDLE, with readValid=0 in the following cycle.
REQ-031 In BURST, en_ReadMat, en_WriteMat and burst_start SHALL be ignored, with no addr_err.
REQ-032 readData SHALL retain its last value when readValid=0.

Reset
REQ-033 With rst_n=0, the state SHALL be IDLE, and readData, readValid, burst_last, busy, addr_err and the burst counter SHALL be 0; memory contents SHALL be unchanged.
REQ-034 Reset asserted during a burst SHALL abort it immediately, and no further elements SHALL be emitted.

Structure
REQ-035 The FSM state encoding SHALL reside in the shared package matrix_pkg; DATA_WIDTH, ROWS, COLS and ADDR_W SHALL remain module parameters.
REQ-036 The burst index counter with its last-element compare SHALL be a sub-module named matrix_burst_ctr.

Verification
REQ-037 Write (3,7)=0xA5, then read (3,7) -> readData=0xA5 with a one-cycle readValid, one cycle after the request.
REQ-038 Fill row 2 with 0x20..0x29, row burst on row 2 with out_ready=1 -> 10 consecutive elements 0x20..0x29, burst_last on 0x29, busy low the cycle after.
REQ-039 Column burst on column 4 with out_ready toggling 1,0,1,0 -> each element held during stall cycles, none lost or duplicated, 10 elements total.
REQ-040 Write (10,0) or burst_start on row 12 -> addr_err one-cycle pulse, memory unchanged, busy=0.
REQ-041 Both enables high, and a write request during BURST -> no memory change, no addr_err.
REQ-042 Assert rst_n=0 on the 4th element of a row burst -> all outputs 0 and state IDLE; a subsequent read of (0,0) returns the pre-reset value.
